// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: states, opcodes,
// instruction classes, aluop codes and the per-class execute control helper.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_LW  = 3'd1,
    CLS_SW  = 3'd2,
    CLS_BEQ = 3'd3,
    CLS_ORI = 3'd4,
    CLS_LUI = 3'd5
  } cls_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_ILOGIC = 2'b11;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       regdst;
  } exec_ctl_t;

  // Execute-unit controls for a class; held from EXEC through WB.
  function automatic exec_ctl_t exec_ctl(input cls_t cls);
    exec_ctl_t c;
    c = '0;
    case (cls)
      CLS_R: begin
        c.aluop  = ALUOP_FUNCT;
        c.regdst = 1'b1;
      end
      CLS_LW, CLS_SW: begin
        c.aluop  = ALUOP_ADD;
        c.alusrc = 1'b1;
      end
      CLS_BEQ: c.aluop = ALUOP_SUB;
      CLS_ORI, CLS_LUI: begin
        c.aluop  = ALUOP_ILOGIC;
        c.alusrc = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode classifier: maps instruction[31:26] to an instruction class,
// flagging anything outside the supported set as illegal.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  output cls_t       o_cls,
  output logic       o_illegal
);

  always_comb begin
    o_cls     = CLS_R;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_R:    o_cls = CLS_R;
      OP_LW:   o_cls = CLS_LW;
      OP_SW:   o_cls = CLS_SW;
      OP_BEQ:  o_cls = CLS_BEQ;
      OP_ORI:  o_cls = CLS_ORI;
      OP_LUI:  o_cls = CLS_LUI;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencing FSM for the MIPS datapath. Defining
// MULTICYCLE_CTRL_PERF_EN adds saturating cycle/retired performance counters.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             do_branch,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       aluop,
  output logic             alusrc,
  output logic             regdst,
  output logic             branch,
  output logic             reg_write,
  output logic             memtoreg,
  output logic             illegal,
  output logic [2:0]       state_dbg
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count
`endif
);

  state_t     r_state, w_next_state;
  cls_t       r_cls, w_dec_cls;
  logic       r_illegal, w_dec_illegal;
  exec_ctl_t  w_ctl;
  logic       w_mem_read, w_mem_write, w_iord, w_ir_write, w_pc_write, w_pc_src;
  logic [1:0] w_aluop;
  logic       w_alusrc, w_regdst, w_branch, w_reg_write, w_memtoreg;

  ctrl_decode u_decode (
    .i_opcode  (opcode),
    .o_cls     (w_dec_cls),
    .o_illegal (w_dec_illegal)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_cls     <= CLS_R;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) begin
        if (w_dec_illegal) r_illegal <= 1'b1;
        else               r_cls     <= w_dec_cls;
      end
    end
  end

  // Next state and strobe decode from registered state/class.
  always_comb begin
    w_next_state = r_state;
    w_ctl        = exec_ctl(r_cls);
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_iord       = 1'b0;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_pc_src     = 1'b0;
    w_aluop      = ALUOP_ADD;
    w_alusrc     = 1'b0;
    w_regdst     = 1'b0;
    w_branch     = 1'b0;
    w_reg_write  = 1'b0;
    w_memtoreg   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (mem_ready) begin
          w_ir_write   = 1'b1;
          w_pc_write   = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: w_next_state = w_dec_illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        w_aluop  = w_ctl.aluop;
        w_alusrc = w_ctl.alusrc;
        w_regdst = w_ctl.regdst;
        case (r_cls)
          CLS_LW, CLS_SW: w_next_state = S_MEM;
          CLS_BEQ: begin
            w_branch     = 1'b1;
            w_pc_write   = do_branch;
            w_pc_src     = do_branch;
            w_next_state = S_FETCH;
          end
          default: w_next_state = S_WB;
        endcase
      end
      S_MEM: begin
        w_aluop  = w_ctl.aluop;
        w_alusrc = w_ctl.alusrc;
        w_regdst = w_ctl.regdst;
        w_iord   = 1'b1;
        if (r_cls == CLS_LW) begin
          w_mem_read = 1'b1;
          if (mem_ready) w_next_state = S_WB;
        end else begin
          w_mem_write = 1'b1;
          if (mem_ready) w_next_state = S_FETCH;
        end
      end
      S_WB: begin
        w_aluop      = w_ctl.aluop;
        w_alusrc     = w_ctl.alusrc;
        w_regdst     = w_ctl.regdst;
        w_reg_write  = 1'b1;
        w_memtoreg   = (r_cls == CLS_LW);
        w_next_state = S_FETCH;
      end
      S_TRAP:  w_next_state = S_TRAP;
      default: w_next_state = S_FETCH;
    endcase
  end

  // Reset forces every strobe low immediately, abandoning any pending access.
  assign mem_read  = w_mem_read  & ~reset;
  assign mem_write = w_mem_write & ~reset;
  assign iord      = w_iord      & ~reset;
  assign ir_write  = w_ir_write  & ~reset;
  assign pc_write  = w_pc_write  & ~reset;
  assign pc_src    = w_pc_src    & ~reset;
  assign aluop     = w_aluop     & {2{~reset}};
  assign alusrc    = w_alusrc    & ~reset;
  assign regdst    = w_regdst    & ~reset;
  assign branch    = w_branch    & ~reset;
  assign reg_write = w_reg_write & ~reset;
  assign memtoreg  = w_memtoreg  & ~reset;
  assign illegal   = r_illegal;
  assign state_dbg = r_state;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_cycle_count, r_retired_count;
  logic             w_retire;

  assign w_retire = (r_state == S_WB) ||
                    (r_state == S_MEM  && r_cls == CLS_SW && mem_ready) ||
                    (r_state == S_EXEC && r_cls == CLS_BEQ);

  // Saturating counters; cycle count freezes while trapped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle_count   <= '0;
      r_retired_count <= '0;
    end else begin
      if (r_state != S_TRAP && r_cycle_count != '1)
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      if (w_retire && r_retired_count != '1)
        r_retired_count <= r_retired_count + CNT_W'(1);
    end
  end

  assign cycle_count   = r_cycle_count;
  assign retired_count = r_retired_count;
`else
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected state/strobe vectors
// are queued as stimulus is applied and checked when the outputs settle.
module tb_multicycle_ctrl;

  logic        clock;
  logic        reset;
  logic [5:0]  opcode;
  logic        do_branch;
  logic        mem_ready;
  logic        mem_read, mem_write, iord, ir_write, pc_write, pc_src;
  logic [1:0]  aluop;
  logic        alusrc, regdst, branch, reg_write, memtoreg, illegal;
  logic [2:0]  state_dbg;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_count, retired_count;
`endif

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .opcode    (opcode),
    .do_branch (do_branch),
    .mem_ready (mem_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .iord      (iord),
    .ir_write  (ir_write),
    .pc_write  (pc_write),
    .pc_src    (pc_src),
    .aluop     (aluop),
    .alusrc    (alusrc),
    .regdst    (regdst),
    .branch    (branch),
    .reg_write (reg_write),
    .memtoreg  (memtoreg),
    .illegal   (illegal),
    .state_dbg (state_dbg)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_count   (cycle_count),
    .retired_count (retired_count)
`endif
  );

  typedef struct packed {
    logic [2:0]  st;
    logic [13:0] sig;
    logic [13:0] mask;
  } exp_t;

  exp_t q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  localparam logic [13:0] M_ALL  = 14'h3FFF;
  localparam logic [13:0] M_NORD = 14'h3FEF;
  localparam logic [5:0]  OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0]  OP_BEQ = 6'b000100, OP_BAD = 6'b111111;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {mem_read,mem_write,iord,ir_write,pc_write,pc_src,aluop,alusrc,regdst,branch,reg_write,memtoreg,illegal}
  function automatic logic [13:0] mk(input logic mr, input logic mw, input logic io,
                                     input logic irw, input logic pcw, input logic pcs,
                                     input logic [1:0] ao, input logic as, input logic rd,
                                     input logic br, input logic rw, input logic m2r,
                                     input logic ill);
    return {mr, mw, io, irw, pcw, pcs, ao, as, rd, br, rw, m2r, ill};
  endfunction

  task automatic step(input logic rst_i, input logic mr, input logic db, input logic [5:0] op,
                      input logic [2:0] st, input logic [13:0] sig, input logic [13:0] mask,
                      input string tag);
    exp_t        e;
    exp_t        got;
    logic [13:0] obs;
    @(negedge clock);
    reset     = rst_i;
    mem_ready = mr;
    do_branch = db;
    opcode    = op;
    e.st = st; e.sig = sig; e.mask = mask;
    q.push_back(e);
    #1;
    got = q.pop_front();
    obs = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, aluop, alusrc,
           regdst, branch, reg_write, memtoreg, illegal};
    n_assert++;
    assert (state_dbg === got.st) else begin
      n_fail++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state_dbg, got.st);
    end
    n_assert++;
    assert ((obs & got.mask) === (got.sig & got.mask)) else begin
      n_fail++;
      $error("FAIL %s strobes observed=%b expected=%b mask=%b", tag, obs, got.sig, got.mask);
    end
    n_assert++;
    assert (!(mem_read && mem_write) && !(reg_write && mem_write)) else begin
      n_fail++;
      $error("FAIL %s exclusive observed mr=%b mw=%b rw=%b expected no overlap",
             tag, mem_read, mem_write, reg_write);
    end
  endtask

  logic [13:0] f_rdy, f_wait, zero, trap_v;
  logic [13:0] lw_mem, lwsw_exec;

  initial begin
    reset = 1'b1; opcode = '0; do_branch = 1'b0; mem_ready = 1'b0;
    f_rdy     = mk(1,0,0,1,1,0,2'b00,0,0,0,0,0,0);
    f_wait    = mk(1,0,0,0,0,0,2'b00,0,0,0,0,0,0);
    zero      = '0;
    trap_v    = mk(0,0,0,0,0,0,2'b00,0,0,0,0,0,1);
    lw_mem    = mk(1,0,1,0,0,0,2'b00,1,0,0,0,0,0);
    lwsw_exec = mk(0,0,0,0,0,0,2'b00,1,0,0,0,0,0);

    step(1, 1, 0, OP_R, 3'd0, zero, M_ALL, "reset");

    // add, zero wait; do_branch during EXEC must be ignored
    step(0, 1, 0, OP_R, 3'd0, f_rdy, M_ALL, "add_fetch");
    step(0, 1, 0, OP_R, 3'd1, zero, M_ALL, "add_decode");
    step(0, 1, 1, OP_R, 3'd2, mk(0,0,0,0,0,0,2'b10,0,0,0,0,0,0), M_NORD, "add_exec");
    step(0, 1, 0, OP_R, 3'd4, mk(0,0,0,0,0,0,2'b10,0,1,0,1,0,0), M_ALL, "add_wb");

    // lw with two MEM wait cycles
    step(0, 1, 0, OP_LW, 3'd0, f_rdy, M_ALL, "lw_fetch");
    step(0, 1, 0, OP_LW, 3'd1, zero, M_ALL, "lw_decode");
    step(0, 1, 0, OP_LW, 3'd2, lwsw_exec, M_NORD, "lw_exec");
    step(0, 0, 0, OP_LW, 3'd3, lw_mem, M_ALL, "lw_mem_w1");
    step(0, 0, 0, OP_LW, 3'd3, lw_mem, M_ALL, "lw_mem_w2");
    step(0, 1, 0, OP_LW, 3'd3, lw_mem, M_ALL, "lw_mem_rdy");
    step(0, 1, 0, OP_LW, 3'd4, mk(0,0,0,0,0,0,2'b00,1,0,0,1,1,0), M_ALL, "lw_wb");

    // beq taken, then not taken
    step(0, 1, 0, OP_BEQ, 3'd0, f_rdy, M_ALL, "beq_t_fetch");
    step(0, 1, 0, OP_BEQ, 3'd1, zero, M_ALL, "beq_t_decode");
    step(0, 1, 1, OP_BEQ, 3'd2, mk(0,0,0,0,1,1,2'b01,0,0,1,0,0,0), M_NORD, "beq_t_exec");
    step(0, 1, 1, OP_BEQ, 3'd0, f_rdy, M_ALL, "beq_n_fetch");
    step(0, 1, 1, OP_BEQ, 3'd1, zero, M_ALL, "beq_n_decode");
    step(0, 1, 0, OP_BEQ, 3'd2, mk(0,0,0,0,0,0,2'b01,0,0,1,0,0,0), M_NORD, "beq_n_exec");

    // sw with one FETCH wait cycle
    step(0, 0, 0, OP_SW, 3'd0, f_wait, M_ALL, "sw_fetch_wait");
    step(0, 1, 0, OP_SW, 3'd0, f_rdy, M_ALL, "sw_fetch");
    step(0, 1, 0, OP_SW, 3'd1, zero, M_ALL, "sw_decode");
    step(0, 1, 0, OP_SW, 3'd2, lwsw_exec, M_NORD, "sw_exec");
    step(0, 1, 0, OP_SW, 3'd3, mk(0,1,1,0,0,0,2'b00,1,0,0,0,0,0), M_ALL, "sw_mem");

    // illegal opcode traps until reset
    step(0, 1, 0, OP_BAD, 3'd0, f_rdy, M_ALL, "bad_fetch");
    step(0, 1, 0, OP_BAD, 3'd1, zero, M_ALL, "bad_decode");
    for (int i = 0; i < 20; i++)
      step(0, 1'(i % 2), 1'(i % 3 == 0), OP_R, 3'd5, trap_v, M_ALL, "trap_hold");
    step(1, 1, 0, OP_R, 3'd0, zero, M_ALL, "trap_reset");

    // reset pulse in the middle of a lw memory read
    step(0, 1, 0, OP_LW, 3'd0, f_rdy, M_ALL, "lw2_fetch");
    step(0, 1, 0, OP_LW, 3'd1, zero, M_ALL, "lw2_decode");
    step(0, 1, 0, OP_LW, 3'd2, lwsw_exec, M_NORD, "lw2_exec");
    step(0, 0, 0, OP_LW, 3'd3, lw_mem, M_ALL, "lw2_mem");
    step(1, 0, 0, OP_LW, 3'd0, zero, M_ALL, "rst_mid_mem");
    step(1, 1, 0, OP_R, 3'd0, zero, M_ALL, "rst_hold");
`ifdef MULTICYCLE_CTRL_PERF_EN
    n_assert++;
    assert (cycle_count === 32'd0 && retired_count === 32'd0) else begin
      n_fail++;
      $error("FAIL perf_reset observed cyc=%0d ret=%0d expected 0/0", cycle_count, retired_count);
    end
`endif

    // add, lw, sw back to back with zero wait
    step(0, 1, 0, OP_R, 3'd0, f_rdy, M_ALL, "p_add_fetch");
    step(0, 1, 0, OP_R, 3'd1, zero, M_ALL, "p_add_decode");
    step(0, 1, 0, OP_R, 3'd2, mk(0,0,0,0,0,0,2'b10,0,0,0,0,0,0), M_NORD, "p_add_exec");
    step(0, 1, 0, OP_R, 3'd4, mk(0,0,0,0,0,0,2'b10,0,1,0,1,0,0), M_ALL, "p_add_wb");
    step(0, 1, 0, OP_LW, 3'd0, f_rdy, M_ALL, "p_lw_fetch");
    step(0, 1, 0, OP_LW, 3'd1, zero, M_ALL, "p_lw_decode");
    step(0, 1, 0, OP_LW, 3'd2, lwsw_exec, M_NORD, "p_lw_exec");
    step(0, 1, 0, OP_LW, 3'd3, lw_mem, M_ALL, "p_lw_mem");
    step(0, 1, 0, OP_LW, 3'd4, mk(0,0,0,0,0,0,2'b00,1,0,0,1,1,0), M_ALL, "p_lw_wb");
    step(0, 1, 0, OP_SW, 3'd0, f_rdy, M_ALL, "p_sw_fetch");
    step(0, 1, 0, OP_SW, 3'd1, zero, M_ALL, "p_sw_decode");
    step(0, 1, 0, OP_SW, 3'd2, lwsw_exec, M_NORD, "p_sw_exec");
    step(0, 1, 0, OP_SW, 3'd3, mk(0,1,1,0,0,0,2'b00,1,0,0,0,0,0), M_ALL, "p_sw_mem");
    step(0, 0, 0, OP_R, 3'd0, f_wait, M_ALL, "p_idle");
`ifdef MULTICYCLE_CTRL_PERF_EN
    n_assert++;
    assert (retired_count === 32'd3) else begin
      n_fail++;
      $error("FAIL perf_retired observed=%0d expected=3", retired_count);
    end
    n_assert++;
    assert (cycle_count === 32'd13) else begin
      n_fail++;
      $error("FAIL perf_cycles observed=%0d expected=13", cycle_count);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
